// File: rtl/rv32i_types.sv
// Shared types for the instruction/data memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, SERVE_I, SERVE_D)
//   req_id_t    : requester identity used for round-robin tie breaking
//   mem_req_t   : request image latched on the grant edge and driven onto
//                 the shared memory port
package rv32i_types;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        IMEM = 1'b0,
        DMEM = 1'b1
    } req_id_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] rmask;
        logic [MASK_W-1:0] wmask;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Fetches never write; the write fields are zero.
    function automatic mem_req_t make_imem_req(
        input logic [ADDR_W-1:0] addr,
        input logic [MASK_W-1:0] rmask
    );
        mem_req_t req;
        req.addr  = addr;
        req.rmask = rmask;
        req.wmask = {MASK_W{1'b0}};
        req.wdata = {DATA_W{1'b0}};
        return req;
    endfunction

    // A store suppresses any read mask presented alongside it.
    function automatic mem_req_t make_dmem_req(
        input logic [ADDR_W-1:0] addr,
        input logic [MASK_W-1:0] rmask,
        input logic [MASK_W-1:0] wmask,
        input logic [DATA_W-1:0] wdata
    );
        mem_req_t req;
        req.addr  = addr;
        req.wmask = wmask;
        req.wdata = wdata;
        if (wmask != {MASK_W{1'b0}}) begin
            req.rmask = {MASK_W{1'b0}};
        end else begin
            req.rmask = rmask;
        end
        return req;
    endfunction

endpackage

// File: rtl/mem_arbiter_timeout_ctr.sv
// Busy-cycle watchdog for the shared memory port.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : grant edge, restarts the count
//   busy       : a transaction is in service this cycle
//   done       : memory completes the transaction this cycle
//   err        : sticky, set once TIMEOUT busy cycles have elapsed
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic busy,
    input  logic done,
    output logic err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          r_err;

    // Next count: clear on grant, count stalled busy cycles, saturate at LIMIT.
    always_comb begin
        w_count_next = r_count;
        if (clear) begin
            w_count_next = {CW{1'b0}};
        end else if (busy && !done && (r_count != LIMIT)) begin
            w_count_next = r_count + ONE;
        end else begin
            w_count_next = r_count;
        end
    end

    // Count register and sticky error flag; err rises on the edge the count reaches LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CW{1'b0}};
            r_err   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_err   <= r_err | (w_count_next == LIMIT);
        end
    end

    assign err = r_err;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch
// (imem) and load/store (dmem). Ties alternate between requesters.
//   clk, rst_n                        : clock, asynchronous active-low reset
//   imem_addr/rmask -> rdata/resp     : fetch request and completion
//   dmem_addr/rmask/wmask/wdata -> rdata/resp : load/store request and completion
//   mem_addr/rmask/wmask/wdata        : shared port request (registered)
//   mem_rdata/resp                    : shared port data and completion
//   err                               : sticky busy-timeout flag
module mem_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        err
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    req_id_t    r_last_grant;
    mem_req_t   r_req;
    logic       w_imem_pend;
    logic       w_dmem_pend;
    logic       w_grant;
    logic       w_busy;

    assign w_imem_pend = (imem_rmask != 4'h0);
    assign w_dmem_pend = (dmem_rmask != 4'h0) || (dmem_wmask != 4'h0);
    assign w_grant     = (r_state == IDLE) && (w_next_state != IDLE);
    assign w_busy      = (r_state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: arbitrate only in IDLE, leave service on mem_resp.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_imem_pend && w_dmem_pend) begin
                    // Tie: favour whoever was not served last.
                    w_next_state = (r_last_grant == IMEM) ? SERVE_D : SERVE_I;
                end else if (w_imem_pend) begin
                    w_next_state = SERVE_I;
                end else if (w_dmem_pend) begin
                    w_next_state = SERVE_D;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Output logic: completion is forwarded combinationally in the resp cycle.
    always_comb begin
        imem_resp  = 1'b0;
        imem_rdata = 32'h0000_0000;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0000_0000;
        case (r_state)
            SERVE_I: begin
                if (mem_resp) begin
                    imem_resp  = 1'b1;
                    imem_rdata = mem_rdata;
                end else begin
                    imem_resp  = 1'b0;
                end
            end
            SERVE_D: begin
                if (mem_resp) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = mem_rdata;
                end else begin
                    dmem_resp  = 1'b0;
                end
            end
            default: begin
                imem_resp = 1'b0;
                dmem_resp = 1'b0;
            end
        endcase
    end

    // Request latch and last-grant tracking. The latch is cleared on completion
    // so the port masks read zero whenever the arbiter is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req        <= {$bits(mem_req_t){1'b0}};
            r_last_grant <= IMEM;
        end else if (w_grant) begin
            if (w_next_state == SERVE_I) begin
                r_req <= make_imem_req(imem_addr, imem_rmask);
            end else begin
                r_req <= make_dmem_req(dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata);
            end
        end else if (w_busy && mem_resp) begin
            r_req        <= {$bits(mem_req_t){1'b0}};
            r_last_grant <= (r_state == SERVE_D) ? DMEM : IMEM;
        end else begin
            r_req        <= r_req;
            r_last_grant <= r_last_grant;
        end
    end

    assign mem_addr  = r_req.addr;
    assign mem_rmask = r_req.rmask;
    assign mem_wmask = r_req.wmask;
    assign mem_wdata = r_req.wdata;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_grant),
        .busy  (w_busy),
        .done  (mem_resp),
        .err   (err)
    );

endmodule
